// File: rtl/gpo_cmd_sequencer_if.sv
// Command/response handshake bundle between a host and the GPO command sequencer.
interface gpo_cmd_sequencer_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd;
  logic [22:0] i_cmd_data;
  logic        i_abort;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_last;
  logic        o_rsp_err;

  modport slave (
    input  i_cmd_valid, i_cmd, i_cmd_data, i_abort, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_last, o_rsp_err
  );

  modport master (
    output i_cmd_valid, i_cmd, i_cmd_data, i_abort, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_last, o_rsp_err
  );
endinterface

// File: rtl/gpo_cmd_sequencer.sv
// Drives registerFile GPO with a timed enable strobe, samples GPI, returns it as a response.
// DUMP expands into READ_MEM on, one ADDR_MEM per log word, READ_MEM off.
module gpo_cmd_sequencer #(
  parameter int         NB_ADDR_MEM = 15,
  parameter int         STROBE_CYC  = 2,
  parameter int         SETTLE_CYC  = 2,
  parameter logic [7:0] DUMP_OPCODE = 8'hFF
) (
  input  logic                clk,
  input  logic                i_rst_n,
  gpo_cmd_sequencer_if.slave  bus,
  output logic                o_busy,
  output logic [31:0]         o_gpo,
  input  logic [31:0]         i_gpi
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_STROBE = 3'd2, S_SETTLE = 3'd3,
                         S_CAPTURE = 3'd4, S_RESP = 3'd5, S_ERR_RESP = 3'd6;
  localparam logic [1:0] PH_SINGLE = 2'd0, PH_ON = 2'd1, PH_WORD = 2'd2, PH_OFF = 2'd3;
  localparam logic [7:0] OP_READ_MEM = 8'd5, OP_ADDR_MEM = 8'd6;

  logic [2:0]             state_q, state_d;
  logic [1:0]             ph_q, ph_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [NB_ADDR_MEM:0]   addr_q, addr_d, addr_nxt;
  logic [NB_ADDR_MEM-1:0] last_q, last_d;
  logic                   abort_q, abort_d, abort_eff;
  logic [31:0]            gpo_q, gpo_d;
  logic                   rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   rdy_en_q;

  function automatic logic [31:0] txn(input logic [7:0] cmd, input logic [22:0] data);
    return {cmd, 1'b0, data};
  endfunction

  assign addr_nxt = addr_q + 1'b1;
  // Abort only means something while a DUMP is in flight.
  assign abort_eff = abort_q | (bus.i_abort & (ph_q != PH_SINGLE));

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    last_d      = last_q;
    abort_d     = abort_eff;
    gpo_d       = gpo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        cnt_d   = 8'd0;
        if (bus.i_cmd_valid && rdy_en_q) begin
          if (bus.i_cmd == DUMP_OPCODE) begin
            ph_d    = PH_ON;
            last_d  = bus.i_cmd_data[NB_ADDR_MEM-1:0];
            addr_d  = '0;
            gpo_d   = txn(OP_READ_MEM, 23'd1);
            state_d = S_SETUP;
          end else if (bus.i_cmd <= 8'd11) begin
            ph_d    = PH_SINGLE;
            gpo_d   = txn(bus.i_cmd, bus.i_cmd_data);
            state_d = S_SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_data_d  = 32'd0;
            state_d     = S_ERR_RESP;
          end
        end
      end
      S_SETUP: begin
        gpo_d[23] = 1'b1;
        cnt_d     = 8'd0;
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == 8'(STROBE_CYC - 1)) begin
          gpo_d[23] = 1'b0;
          cnt_d     = 8'd0;
          state_d   = S_SETTLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_SETTLE: begin
        if (cnt_q == 8'(SETTLE_CYC - 1)) state_d = S_CAPTURE;
        else cnt_d = cnt_q + 8'd1;
      end
      S_CAPTURE: begin
        case (ph_q)
          PH_ON: begin
            state_d = S_SETUP;
            if (abort_eff) begin
              ph_d  = PH_OFF;
              gpo_d = txn(OP_READ_MEM, 23'd0);
            end else begin
              ph_d  = PH_WORD;
              gpo_d = txn(OP_ADDR_MEM, 23'(addr_q));
            end
          end
          PH_OFF: begin
            ph_d    = PH_SINGLE;
            state_d = S_IDLE;
          end
          default: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = i_gpi;
            rsp_err_d   = 1'b0;
            rsp_last_d  = (ph_q == PH_SINGLE) | (addr_q == {1'b0, last_q}) | abort_eff;
            abort_d     = 1'b0;
            state_d     = S_RESP;
          end
        endcase
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (ph_q == PH_WORD) begin
            state_d = S_SETUP;
            if (rsp_last_q) begin
              ph_d  = PH_OFF;
              gpo_d = txn(OP_READ_MEM, 23'd0);
            end else begin
              addr_d = addr_nxt;
              gpo_d  = txn(OP_ADDR_MEM, 23'(addr_nxt));
            end
          end else state_d = S_IDLE;
        end
      end
      S_ERR_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ph_q        <= PH_SINGLE;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      last_q      <= '0;
      abort_q     <= 1'b0;
      gpo_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
      gpo_q       <= gpo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // Ready stays low through reset and rises one edge after release.
  assign bus.o_cmd_ready = rdy_en_q & (state_q == S_IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_last  = rsp_last_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_gpo           = gpo_q;
endmodule

// File: tb/tb_gpo_cmd_sequencer.sv
// Directed bench for gpo_cmd_sequencer: single, back-pressure, error, dump, abort, reset.
module tb_gpo_cmd_sequencer;
  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [31:0] gpo;
  logic [31:0] gpi;
  logic        gpi_mode;
  logic [31:0] gpi_reg;
  int          errs, checks;

  logic [31:0] txq[$];
  logic [31:0] rdq[$];
  logic        rlq[$];

  gpo_cmd_sequencer_if sif();

  gpo_cmd_sequencer dut (
    .clk(clk), .i_rst_n(rst_n), .bus(sif), .o_busy(busy), .o_gpo(gpo), .i_gpi(gpi)
  );

  // registerFile stand-in: echoes opcode and low data bits, scrambled.
  assign gpi = gpi_mode ? {8'hC3, gpo[31:24], gpo[15:0] ^ 16'h5A5A} : gpi_reg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] cmd, input logic [22:0] data);
    @(negedge clk);
    sif.i_cmd_valid = 1'b1;
    sif.i_cmd       = cmd;
    sif.i_cmd_data  = data;
    @(negedge clk);
    sif.i_cmd_valid = 1'b0;
  endtask

  // Runs one DUMP with rsp_ready high, logging GPO transactions and responses.
  task automatic run_dump(input logic [14:0] L, input int abort_addr, output bit done);
    logic prev;
    txq.delete(); rdq.delete(); rlq.delete();
    sif.i_rsp_ready = 1'b1;
    send(8'hFF, {8'h00, L});
    prev = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      sif.i_abort = 1'b0;
      if (gpo[23] && !prev) begin
        txq.push_back(gpo & 32'hFF7F_FFFF);
        if (abort_addr >= 0 && gpo[31:24] == 8'h06 && int'(gpo[15:0]) == abort_addr)
          sif.i_abort = 1'b1;
      end
      prev = gpo[23];
      if (sif.o_rsp_valid && sif.i_rsp_ready) begin
        rdq.push_back(sif.o_rsp_data);
        rlq.push_back(sif.o_rsp_last);
      end
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    sif.i_abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gpo !== 32'd0) begin errs++; $display("FAIL reset_gpo got=%h exp=0", gpo); end
    checks++; if (sif.o_rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got=%b exp=0", sif.o_rsp_valid); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sif.o_cmd_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", sif.o_cmd_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (sif.o_cmd_ready !== 1'b0) begin errs++; $display("FAIL release_ready_early got=%b exp=0", sif.o_cmd_ready); end
    @(negedge clk);
    checks++; if (sif.o_cmd_ready !== 1'b1) begin errs++; $display("FAIL release_ready got=%b exp=1", sif.o_cmd_ready); end
  endtask

  task automatic test_single();
    logic [31:0] g[7];
    int nstr, fstr, fval;
    logic [31:0] rd; logic rl, re;
    nstr = 0; fstr = -1; fval = -1; rd = '0; rl = 1'b0; re = 1'b1;
    gpi_mode = 1'b0; gpi_reg = 32'h1000_0000; sif.i_rsp_ready = 1'b0;
    send(8'h01, 23'd1);
    for (int c = 0; c < 7; c++) begin
      g[c] = gpo;
      if (gpo[23]) begin nstr++; if (fstr < 0) fstr = c; end
      if (sif.o_rsp_valid && fval < 0) begin
        fval = c; rd = sif.o_rsp_data; rl = sif.o_rsp_last; re = sif.o_rsp_err;
      end
      gpi_reg = 32'h1000_0000 + 32'(c);
      if (c < 6) @(negedge clk);
    end
    checks++; if (g[0] !== 32'h0100_0001) begin errs++; $display("FAIL t1_setup_gpo got=%h exp=01000001", g[0]); end
    checks++; if (g[1] !== 32'h0180_0001) begin errs++; $display("FAIL t1_strobe_gpo got=%h exp=01800001", g[1]); end
    checks++; if (g[3] !== 32'h0100_0001) begin errs++; $display("FAIL t1_settle_gpo got=%h exp=01000001", g[3]); end
    checks++; if (nstr !== 2 || fstr !== 1) begin errs++; $display("FAIL t1_strobe_len got=%0d@%0d exp=2@1", nstr, fstr); end
    checks++; if (fval !== 6) begin errs++; $display("FAIL t1_rsp_latency got=%0d exp=6", fval); end
    checks++; if (rd !== 32'h1000_0005) begin errs++; $display("FAIL t1_rsp_data got=%h exp=10000005", rd); end
    checks++; if (rl !== 1'b1 || re !== 1'b0) begin errs++; $display("FAIL t1_last_err got=%b%b exp=10", rl, re); end
    sif.i_rsp_ready = 1'b1;
    @(negedge clk);
    sif.i_rsp_ready = 1'b0;
    checks++; if (sif.o_rsp_valid !== 1'b0 || sif.o_cmd_ready !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL t1_done got=v%b r%b b%b exp=v0 r1 b0", sif.o_rsp_valid, sif.o_cmd_ready, busy); end
    gpi_mode = 1'b1;
  endtask

  task automatic test_backpressure();
    bit seen;
    sif.i_rsp_ready = 1'b0;
    send(8'h03, 23'd2);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (sif.o_rsp_valid) seen = 1'b1; else @(negedge clk);
    end
    checks++; if (!seen) begin errs++; $display("FAIL t2_rsp_timeout got=0 exp=1"); end
    // Late input changes while busy must not be taken.
    sif.i_cmd_valid = 1'b1; sif.i_cmd = 8'h01; sif.i_cmd_data = 23'h7F_FFFF;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (sif.o_rsp_valid !== 1'b1 || sif.o_rsp_data !== 32'hC303_5A58 || sif.o_cmd_ready !== 1'b0)
        begin errs++; $display("FAIL t2_hold c=%0d got=v%b d=%h r%b exp=v1 d=c3035a58 r0", c, sif.o_rsp_valid, sif.o_rsp_data, sif.o_cmd_ready); end
      @(negedge clk);
    end
    sif.i_cmd_valid = 1'b0;
    sif.i_rsp_ready = 1'b1;
    @(negedge clk);
    sif.i_rsp_ready = 1'b0;
    checks++; if (sif.o_rsp_valid !== 1'b0 || sif.o_cmd_ready !== 1'b1)
      begin errs++; $display("FAIL t2_release got=v%b r%b exp=v0 r1", sif.o_rsp_valid, sif.o_cmd_ready); end
    checks++; if (gpo !== 32'h0300_0002) begin errs++; $display("FAIL t2_gpo_idle got=%h exp=03000002", gpo); end
  endtask

  task automatic test_error();
    sif.i_rsp_ready = 1'b0;
    send(8'h20, 23'h12_3456);
    checks++; if (sif.o_rsp_valid !== 1'b1 || sif.o_rsp_err !== 1'b1 || sif.o_rsp_last !== 1'b1 || sif.o_rsp_data !== 32'd0)
      begin errs++; $display("FAIL t3_err_rsp got=v%b e%b l%b d=%h exp=v1 e1 l1 d=0", sif.o_rsp_valid, sif.o_rsp_err, sif.o_rsp_last, sif.o_rsp_data); end
    checks++; if (gpo !== 32'h0300_0002) begin errs++; $display("FAIL t3_gpo got=%h exp=03000002", gpo); end
    sif.i_rsp_ready = 1'b1;
    @(negedge clk);
    sif.i_rsp_ready = 1'b0;
    checks++; if (sif.o_rsp_valid !== 1'b0 || busy !== 1'b0 || gpo !== 32'h0300_0002)
      begin errs++; $display("FAIL t3_done got=v%b b%b g=%h exp=v0 b0 g=03000002", sif.o_rsp_valid, busy, gpo); end
  endtask

  task automatic test_dump();
    bit done;
    logic [31:0] exp_tx[6];
    logic [31:0] exp_rd[4];
    exp_tx = '{32'h0500_0001, 32'h0600_0000, 32'h0600_0001, 32'h0600_0002, 32'h0600_0003, 32'h0500_0000};
    exp_rd = '{32'hC306_5A5A, 32'hC306_5A5B, 32'hC306_5A58, 32'hC306_5A59};
    run_dump(15'd3, -1, done);
    checks++; if (!done) begin errs++; $display("FAIL t4_timeout got=busy exp=idle"); end
    checks++; if (txq.size() != 6) begin errs++; $display("FAIL t4_txn_count got=%0d exp=6", txq.size()); end
    for (int i = 0; i < 6 && i < txq.size(); i++) begin
      checks++; if (txq[i] !== exp_tx[i]) begin errs++; $display("FAIL t4_txn[%0d] got=%h exp=%h", i, txq[i], exp_tx[i]); end
    end
    checks++; if (rdq.size() != 4) begin errs++; $display("FAIL t4_rsp_count got=%0d exp=4", rdq.size()); end
    for (int i = 0; i < 4 && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i] !== exp_rd[i] || rlq[i] !== (i == 3))
        begin errs++; $display("FAIL t4_rsp[%0d] got=%h/%b exp=%h/%b", i, rdq[i], rlq[i], exp_rd[i], (i == 3)); end
    end
  endtask

  task automatic test_abort();
    bit done;
    logic [31:0] exp_tx[5];
    logic [31:0] exp_rd[3];
    exp_tx = '{32'h0500_0001, 32'h0600_0000, 32'h0600_0001, 32'h0600_0002, 32'h0500_0000};
    exp_rd = '{32'hC306_5A5A, 32'hC306_5A5B, 32'hC306_5A58};
    run_dump(15'd10, 2, done);
    checks++; if (!done) begin errs++; $display("FAIL t5_timeout got=busy exp=idle"); end
    checks++; if (txq.size() != 5) begin errs++; $display("FAIL t5_txn_count got=%0d exp=5", txq.size()); end
    for (int i = 0; i < 5 && i < txq.size(); i++) begin
      checks++; if (txq[i] !== exp_tx[i]) begin errs++; $display("FAIL t5_txn[%0d] got=%h exp=%h", i, txq[i], exp_tx[i]); end
    end
    checks++; if (rdq.size() != 3) begin errs++; $display("FAIL t5_rsp_count got=%0d exp=3", rdq.size()); end
    for (int i = 0; i < 3 && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i] !== exp_rd[i] || rlq[i] !== (i == 2))
        begin errs++; $display("FAIL t5_rsp[%0d] got=%h/%b exp=%h/%b", i, rdq[i], rlq[i], exp_rd[i], (i == 2)); end
    end
  endtask

  task automatic test_reset_mid_dump();
    bit seen;
    sif.i_rsp_ready = 1'b1;
    send(8'hFF, 23'd3);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (gpo[23]) seen = 1'b1; else @(negedge clk);
    end
    checks++; if (!seen) begin errs++; $display("FAIL t6_no_strobe got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    checks++; if (gpo !== 32'd0 || sif.o_rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL t6_reset got=g%h v%b b%b exp=g0 v0 b0", gpo, sif.o_rsp_valid, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (sif.o_cmd_ready !== 1'b1) begin errs++; $display("FAIL t6_ready got=%b exp=1", sif.o_cmd_ready); end
    sif.i_rsp_ready = 1'b0;
    send(8'h02, 23'h55);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (sif.o_rsp_valid) seen = 1'b1; else @(negedge clk);
    end
    checks++;
    if (!seen || sif.o_rsp_data !== 32'hC302_5A0F || sif.o_rsp_last !== 1'b1 || sif.o_rsp_err !== 1'b0)
      begin errs++; $display("FAIL t6_en_rx got=v%b d=%h l%b e%b exp=v1 d=c3025a0f l1 e0", seen, sif.o_rsp_data, sif.o_rsp_last, sif.o_rsp_err); end
    sif.i_rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || sif.o_rsp_valid !== 1'b0)
      begin errs++; $display("FAIL t6_done got=b%b v%b exp=b0 v0", busy, sif.o_rsp_valid); end
  endtask

  initial begin
    errs = 0; checks = 0;
    rst_n = 1'b0; gpi_mode = 1'b1; gpi_reg = '0;
    sif.i_cmd_valid = 1'b0; sif.i_cmd = '0; sif.i_cmd_data = '0;
    sif.i_abort = 1'b0; sif.i_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_error();
    test_dump();
    test_abort();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
